// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: state encoding, instruction field
// positions and the default ALU select width.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    WRITE
  } state_t;

  localparam int OP_W_DEF = 4;
  localparam int IDX_W    = 4;

  localparam int OPC_LSB  = 12;
  localparam int DEST_LSB = 8;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_LSB = 0;

  // True when a 4-bit register index names an existing register.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx, input int n);
    return int'(idx) < n;
  endfunction

endpackage

// File: rtl/reg_decode.sv
// Register index to one-hot enable decoder; all outputs are low when
// i_en is low.
module reg_decode #(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N-1:0]     o_onehot
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign o_onehot[gi] = i_en && (i_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase bus sequencer for one register-to-register ALU instruction.
// Optional macro ALU_SEQ_B_REUSE_EN skips LOAD_B when the B latch already holds srcB.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int OP_W     = OP_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic                alu_a,
  output logic                alu_b,
  output logic [OP_W-1:0]     alu_sel,
  output logic                alu_in_en,
  output logic                alu_out_en,
  output logic                done,
  output logic                err
);

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [IDX_W-1:0] r_dest;
  logic [IDX_W-1:0] r_src_a;
  logic [IDX_W-1:0] r_src_b;
  logic             r_err;

  logic [IDX_W-1:0] w_dest;
  logic [IDX_W-1:0] w_src_a;
  logic [IDX_W-1:0] w_src_b;
  logic             w_legal;
  logic             w_accept;
  logic             w_skip_b;
  logic [IDX_W-1:0] w_out_idx;

  assign w_dest   = instr[DEST_LSB +: IDX_W];
  assign w_src_a  = instr[SRCA_LSB +: IDX_W];
  assign w_src_b  = instr[SRCB_LSB +: IDX_W];
  assign w_legal  = idx_ok(w_dest, NUM_REGS) && idx_ok(w_src_a, NUM_REGS) &&
                    idx_ok(w_src_b, NUM_REGS);
  assign w_accept = (r_state == IDLE) && instr_valid && w_legal;

`ifdef ALU_SEQ_B_REUSE_EN
  logic [IDX_W-1:0] r_b_tag;
  logic             r_b_vld;
  logic             r_skip_b;

  // The B latch keeps its value until reloaded; the tag is invalidated when
  // the register it mirrors is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_tag  <= '0;
      r_b_vld  <= 1'b0;
      r_skip_b <= 1'b0;
    end else begin
      if (w_accept) begin
        r_skip_b <= r_b_vld && (w_src_b == r_b_tag);
      end
      if (r_state == LOAD_B) begin
        r_b_tag <= r_src_b;
        r_b_vld <= 1'b1;
      end else if ((r_state == WRITE) && (r_dest == r_b_tag)) begin
        r_b_vld <= 1'b0;
      end
    end
  end

  assign w_skip_b = r_skip_b;
`else
  assign w_skip_b = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_dest  <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= OP_W'(instr[OPC_LSB +: 4]);
            r_dest  <= w_dest;
            r_src_a <= w_src_a;
            r_src_b <= w_src_b;
            r_state <= LOAD_A;
          end else if (instr_valid) begin
            r_err <= 1'b1;
          end
        end
        LOAD_A:  r_state <= w_skip_b ? EXEC : LOAD_B;
        LOAD_B:  r_state <= EXEC;
        EXEC:    r_state <= WRITE;
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so instr never reaches them combinationally.
  assign w_out_idx   = (r_state == LOAD_B) ? r_src_b : r_src_a;
  assign instr_ready = (r_state == IDLE);
  assign alu_a       = (r_state == LOAD_A);
  assign alu_b       = (r_state == LOAD_B);
  assign alu_in_en   = (r_state == EXEC);
  assign alu_out_en  = (r_state == WRITE);
  assign done        = (r_state == WRITE);
  assign alu_sel     = r_op;
  assign err         = r_err;

  reg_decode #(.N(NUM_REGS), .IDX_W(IDX_W)) u_out_dec (
    .i_idx    (w_out_idx),
    .i_en     ((r_state == LOAD_A) || (r_state == LOAD_B)),
    .o_onehot (reg_out_en)
  );

  reg_decode #(.N(NUM_REGS), .IDX_W(IDX_W)) u_in_dec (
    .i_idx    (r_dest),
    .i_en     (r_state == WRITE),
    .o_onehot (reg_in_en)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer against a per-instruction
// phase model; follows ALU_SEQ_B_REUSE_EN when it is defined.
module tb_alu_sequencer;

  localparam int NR = 8;
  localparam int OW = 4;
`ifdef ALU_SEQ_B_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [NR-1:0] reg_out_en;
  logic [NR-1:0] reg_in_en;
  logic          alu_a;
  logic          alu_b;
  logic [OW-1:0] alu_sel;
  logic          alu_in_en;
  logic          alu_out_en;
  logic          done;
  logic          err;

  alu_sequencer #(.NUM_REGS(NR), .OP_W(OW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .reg_out_en  (reg_out_en),
    .reg_in_en   (reg_in_en),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_in_en   (alu_in_en),
    .alu_out_en  (alu_out_en),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef logic [26:0] obs_t;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   last_b = -1;
  logic [3:0] sel_model = 4'd0;
  obs_t obs;

  assign obs = {reg_out_en, reg_in_en, alu_a, alu_b, alu_in_en, alu_out_en,
                done, err, instr_ready, alu_sel};

  function automatic obs_t pack(input logic [7:0] ro, input logic [7:0] ri,
                                input logic a, input logic b, input logic ie,
                                input logic oe, input logic dn, input logic er,
                                input logic rdy, input logic [3:0] sel);
    return {ro, ri, a, b, ie, oe, dn, er, rdy, sel};
  endfunction

  function automatic logic [7:0] onehot(input int i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  task automatic chk(input string tag, input obs_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit en);
    if (en) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr       = 16'($urandom);
    end
  endtask

  // Called one cycle after the edge that sampled ins with instr_valid high.
  // Returns in the first IDLE cycle after the instruction.
  task automatic expect_seq(input logic [15:0] ins, input string tag, input bit nz);
    int  d, a, b;
    bit  skip;
    logic [3:0] op;
    op = ins[15:12];
    d  = int'(ins[11:8]);
    a  = int'(ins[7:4]);
    b  = int'(ins[3:0]);
    if (d >= NR || a >= NR || b >= NR) begin
      chk({tag, "_err"}, pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 1, 1, sel_model));
      tick();
      chk({tag, "_err_clr"}, pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1, sel_model));
      return;
    end
    skip = REUSE && (last_b == b);
    sel_model = op;
    chk({tag, "_loada"}, pack(onehot(a), 8'h0, 1, 0, 0, 0, 0, 0, 0, op));
    noise(nz);
    tick();
    if (!skip) begin
      chk({tag, "_loadb"}, pack(onehot(b), 8'h0, 0, 1, 0, 0, 0, 0, 0, op));
      last_b = b;
      noise(nz);
      tick();
    end
    chk({tag, "_exec"}, pack(8'h0, 8'h0, 0, 0, 1, 0, 0, 0, 0, op));
    noise(nz);
    tick();
    chk({tag, "_write"}, pack(8'h0, onehot(d), 0, 0, 0, 1, 1, 0, 0, op));
    if (d == last_b) last_b = -1;
    noise(nz);
    tick();
    chk({tag, "_idle"}, pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1, op));
    if (nz) instr_valid = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, input string tag);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    expect_seq(ins, tag, 1'b0);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset) begin
      total++;
      assert (($countones(reg_out_en) + int'(alu_out_en)) <= 1) else begin
        bad++;
        $error("FAIL bus_contention: reg_out_en=%h alu_out_en=%b required at most one driver",
               reg_out_en, alu_out_en);
      end
    end
  end

  initial begin
    int snap;
    logic [15:0] ins;
    reset = 1'b1;
    instr = 16'h0;
    instr_valid = 1'b0;
    tick();
    tick();
    chk("rst_hold", pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1, 4'h0));
    reset = 1'b0;
    tick();
    chk("rst_release", pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1, 4'h0));

    // Reset while in LOAD_B aborts the instruction.
    snap = done_cnt;
    instr = 16'h3512;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("abort_loada", pack(8'h02, 8'h0, 1, 0, 0, 0, 0, 0, 0, 4'h3));
    tick();
    chk("abort_loadb", pack(8'h04, 8'h0, 0, 1, 0, 0, 0, 0, 0, 4'h3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sel_model = 4'h0;
    last_b = -1;
    chk("abort_reset", pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1, 4'h0));
    for (int i = 0; i < 5; i++) tick();
    chk("abort_idle", pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1, 4'h0));
    chk_int("abort_no_done", done_cnt, snap);

    issue(16'h3512, "op3_d5_a1_b2");

    // Valid held high across a busy instruction: the next one waits for IDLE.
    snap = done_cnt;
    instr = 16'h1000;
    instr_valid = 1'b1;
    tick();
    instr = 16'h2111;
    expect_seq(16'h1000, "b2b_first", 1'b0);
    tick();
    instr_valid = 1'b0;
    expect_seq(16'h2111, "b2b_second", 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk_int("b2b_done_pulses", done_cnt - snap, 2);

    snap = done_cnt;
    issue(16'h0903, "illegal_dest9");
    chk_int("illegal_no_done", done_cnt, snap);

    issue(16'h1012, "reuse_seed");
    issue(16'h2032, "reuse_hit");
    issue(16'h1202, "reuse_clobber");
    issue(16'h2132, "reuse_after_clobber");
    issue(16'h4033, "same_src");
    issue(16'h5424, "dest_eq_src");

    for (int n = 0; n < 40; n++) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        tick();
        chk("rnd_gap", pack(8'h0, 8'h0, 0, 0, 0, 0, 0, 0, 1, sel_model));
      end
      ins = {4'($urandom), 4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)),
             4'($urandom_range(0, 2))};
      instr = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      expect_seq(ins, "rnd", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
